dpwm_sequencer: RTL

Sequencing controller for the DPWM ramp counter. It owns a 0→TOP sawtooth that advances by STEP each clkFC cycle and accepts duty-cycle words from the regulator over a valid/ready handshake. New duty values take effect only at period boundaries. It produces complementary high/low gate drives with programmable dead time, and sits between the digital compensator and the power-stage gate drivers.

---
 rtl/dpwm_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dpwm_sequencer.sv
// DPWM ramp sequencer: 0..TOP sawtooth, period-aligned duty updates over valid/ready,
// and complementary high/low gate drives separated by a programmable dead time.
module dpwm_sequencer #(
  parameter int unsigned STEP = 25,
  parameter int unsigned TOP  = 1000,
  parameter int unsigned DEAD = 2,
  parameter int unsigned W    = 10
) (
  input  logic         clkFC,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic [W-1:0] cuenta,
  output logic         period_start,
  output logic         pwm_hi,
  output logic         pwm_lo,
  output logic [1:0]   state
);

  localparam int unsigned RLW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
  localparam logic [W-1:0]   TOP_L  = W'(TOP);
  localparam logic [W-1:0]   STEP_L = W'(STEP);
  localparam logic [RLW-1:0] DEAD_L = RLW'(DEAD);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cuenta_q, cuenta_d;
  logic [W-1:0]   duty_act_q, duty_act_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic           pending_q, pending_d;
  logic           raw_q, raw_d;
  logic [RLW-1:0] rl_q, rl_d;
  logic           hi_q, hi_d;
  logic           lo_q, lo_d;
  logic           ps_q, ps_d;
  logic           boundary, accept, load;

  always_comb begin
    boundary = (state_q != IDLE) && (cuenta_q == TOP_L);
    accept   = duty_valid && !pending_q;

    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = STOP;
      STOP: begin
        if (enable)        state_d = RUN;
        else if (boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || boundary) cuenta_d = '0;
    else                             cuenta_d = cuenta_q + STEP_L;

    // Shadow is applied at a period boundary or when starting from IDLE;
    // accept and load cannot coincide because accept requires pending=0.
    load       = pending_q && (boundary || (state_q == IDLE && enable));
    duty_act_d = duty_act_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    if (load) begin
      duty_act_d = shadow_q;
      pending_d  = 1'b0;
    end
    if (accept) begin
      shadow_d  = (duty_in > TOP_L) ? TOP_L : duty_in;
      pending_d = 1'b1;
    end

    raw_d = (state_q != IDLE) && (cuenta_q < duty_act_q);

    // Run length since the last raw edge; a gate only opens once it reaches DEAD.
    if (raw_d != raw_q)       rl_d = '0;
    else if (rl_q == DEAD_L)  rl_d = rl_q;
    else                      rl_d = rl_q + RLW'(1);

    hi_d = raw_d && (rl_d == DEAD_L);
    lo_d = !raw_d && (rl_d == DEAD_L) && (state_d != IDLE);
    ps_d = (state_d != IDLE) && (cuenta_d == '0);
  end

  always_ff @(posedge clkFC or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cuenta_q   <= '0;
      duty_act_q <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      raw_q      <= 1'b0;
      rl_q       <= '0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cuenta_q   <= cuenta_d;
      duty_act_q <= duty_act_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      raw_q      <= raw_d;
      rl_q       <= rl_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ps_q       <= ps_d;
    end
  end

  assign cuenta       = cuenta_q;
  assign state        = state_q;
  assign duty_ready   = ~pending_q;
  assign period_start = ps_q;
  assign pwm_hi       = hi_q;
  assign pwm_lo       = lo_q;

endmodule
